// File: rtl/seg_scan_display_pkg.sv
// Shared glyph codes and sizing helpers for the multiplexed 7-segment scan driver.
package seg_scan_display_pkg;

   // Blank glyph; also the reset content of both frame buffers.
   localparam logic [7:0] SEG_EMP = 8'h00;

   typedef enum logic {
      BANK_TUBE1,
      BANK_TUBE2
   } bank_e;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Segment pattern (gfedcba, active-high) for a hex nibble.
   function automatic logic [7:0] seg_hex(input logic [3:0] v);
      logic [7:0] g;
      case (v)
         4'h0:    g = 8'h3F;
         4'h1:    g = 8'h06;
         4'h2:    g = 8'h5B;
         4'h3:    g = 8'h4F;
         4'h4:    g = 8'h66;
         4'h5:    g = 8'h6D;
         4'h6:    g = 8'h7D;
         4'h7:    g = 8'h07;
         4'h8:    g = 8'h7F;
         4'h9:    g = 8'h6F;
         4'hA:    g = 8'h77;
         4'hB:    g = 8'h7C;
         4'hC:    g = 8'h39;
         4'hD:    g = 8'h5E;
         4'hE:    g = 8'h79;
         default: g = 8'h71;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/seg_scan_display_tick_gen.sv
// Modulo-MOD counter advancing on en; pulse marks the enabled cycle that completes a period.
module display_tick_gen
   import seg_scan_display_pkg::*;
#(
   parameter int unsigned MOD = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic pulse
);

   localparam int unsigned   CW   = idx_width(MOD);
   localparam logic [CW-1:0] LAST = CW'(MOD - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
      end
   end

   assign pulse = en && (cnt == LAST);

endmodule

// File: rtl/seg_scan_display.sv
// Double-buffered multiplexed 7-segment driver with tick-based scanning,
// per-digit blinking and circular scrolling of frames longer than the display.
module seg_scan_display
   import seg_scan_display_pkg::*;
#(
   parameter int unsigned CLK_HZ        = 100000000,
   parameter int unsigned DIGIT_TICK_HZ = 500,
   parameter int unsigned NUM_DIGITS    = 8,
   parameter int unsigned BANK_SIZE     = 4,
   parameter int unsigned MSG_LEN       = 16,
   parameter int unsigned BLINK_HZ      = 2,
   parameter int unsigned SCROLL_HZ     = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [MSG_LEN*8-1:0]    frame_in,
   input  logic                    frame_valid,
   output logic                    frame_ready,
   input  logic [NUM_DIGITS-1:0]   blink_mask,
   input  logic                    scroll_en,
   output logic [NUM_DIGITS-1:0]   seg_en,
   output logic [7:0]              tube1,
   output logic [7:0]              tube2
);

   localparam int unsigned DIV   = CLK_HZ / DIGIT_TICK_HZ;
   localparam int unsigned BH    = DIGIT_TICK_HZ / (2 * BLINK_HZ);
   localparam int unsigned SP    = DIGIT_TICK_HZ / SCROLL_HZ;
   localparam int unsigned IDX_W = idx_width(NUM_DIGITS);
   localparam int unsigned OFF_W = idx_width(MSG_LEN);
   localparam int unsigned SUM_W = OFF_W + 1;

   localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
   localparam logic [OFF_W-1:0]      LAST_OFF = OFF_W'(MSG_LEN - 1);
   localparam logic [NUM_DIGITS-1:0] DIGIT0   = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

   logic             tick;
   logic             blink_pulse;
   logic             scroll_pulse;
   logic             wrap;
   logic             accept;

   logic [IDX_W-1:0] idx;
   logic [OFF_W-1:0] offset;
   logic             pending;
   logic             scroll_req;
   logic             phase;
   logic [7:0]       active [MSG_LEN];
   logic [7:0]       shadow [MSG_LEN];

   logic [SUM_W-1:0] sum;
   logic [OFF_W-1:0] ptr;
   logic [7:0]       glyph;
   bank_e            bank;

   display_tick_gen #(.MOD(DIV)) u_prescale (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (1'b0),
      .en    (1'b1),
      .pulse (tick)
   );

   display_tick_gen #(.MOD(BH)) u_blink (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (1'b0),
      .en    (tick),
      .pulse (blink_pulse)
   );

   display_tick_gen #(.MOD(SP)) u_scroll (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (!scroll_en),
      .en    (tick && scroll_en),
      .pulse (scroll_pulse)
   );

   assign frame_ready = !pending;
   assign accept      = frame_valid && !pending;
   assign wrap        = tick && (idx == LAST_IDX);

   always_comb begin
      sum = SUM_W'(offset) + SUM_W'(idx);
      if (32'(sum) >= MSG_LEN) begin
         sum = sum - SUM_W'(MSG_LEN);
      end
      ptr   = sum[OFF_W-1:0];
      glyph = active[ptr];
      if (blink_mask[idx] && !phase) begin
         glyph = SEG_EMP;
      end
      bank = (32'(idx) < BANK_SIZE) ? BANK_TUBE1 : BANK_TUBE2;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx   <= '0;
         phase <= 1'b1;
      end else begin
         if (tick) begin
            idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
         end
         if (blink_pulse) begin
            phase <= ~phase;
         end
      end
   end

   // Promotion outranks scrolling at a wrap; a request raised on the wrap's own
   // tick survives because the later assignment wins.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         offset     <= '0;
         pending    <= 1'b0;
         scroll_req <= 1'b0;
         for (int unsigned i = 0; i < MSG_LEN; i++) begin
            active[i] <= SEG_EMP;
            shadow[i] <= SEG_EMP;
         end
      end else begin
         if (accept) begin
            pending <= 1'b1;
            for (int unsigned i = 0; i < MSG_LEN; i++) begin
               shadow[i] <= frame_in[8*i +: 8];
            end
         end
         if (wrap) begin
            if (pending) begin
               active     <= shadow;
               pending    <= 1'b0;
               offset     <= '0;
               scroll_req <= 1'b0;
            end else if (!scroll_en) begin
               offset <= '0;
            end else if (scroll_req) begin
               offset     <= (offset == LAST_OFF) ? '0 : offset + OFF_W'(1);
               scroll_req <= 1'b0;
            end
         end
         if (!scroll_en) begin
            scroll_req <= 1'b0;
         end else if (scroll_pulse) begin
            scroll_req <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         seg_en <= DIGIT0;
         tube1  <= SEG_EMP;
         tube2  <= SEG_EMP;
      end else begin
         seg_en <= DIGIT0 << idx;
         if (bank == BANK_TUBE1) begin
            tube1 <= glyph;
            tube2 <= SEG_EMP;
         end else begin
            tube1 <= SEG_EMP;
            tube2 <= glyph;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench for seg_scan_display: randomized stimulus against a
// count-based behavioural model of the scan/buffer/blink/scroll rules.
module tb_seg_scan_display;

   localparam int unsigned NUM_DIGITS = 8;
   localparam int unsigned BANK_SIZE  = 4;
   localparam int unsigned MSG_LEN    = 16;
   localparam int unsigned DIV        = 10;
   localparam int unsigned BH         = 10;
   localparam int unsigned SP         = 10;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [127:0] frame_in = '0;
   logic         frame_valid = 1'b0;
   logic         frame_ready;
   logic [7:0]   blink_mask = '0;
   logic         scroll_en = 1'b0;
   logic [7:0]   seg_en;
   logic [7:0]   tube1;
   logic [7:0]   tube2;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   seg_scan_display #(
      .CLK_HZ        (1000),
      .DIGIT_TICK_HZ (100),
      .NUM_DIGITS    (8),
      .BANK_SIZE     (4),
      .MSG_LEN       (16),
      .BLINK_HZ      (5),
      .SCROLL_HZ     (10)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_in    (frame_in),
      .frame_valid (frame_valid),
      .frame_ready (frame_ready),
      .blink_mask  (blink_mask),
      .scroll_en   (scroll_en),
      .seg_en      (seg_en),
      .tube1       (tube1),
      .tube2       (tube2)
   );

   // Model state: everything is derived from cycle and tick counts since reset.
   int unsigned m_cyc, m_ticks, m_sc, m_off;
   bit          m_pend, m_req;
   logic [7:0]  m_active [16];
   logic [7:0]  m_shadow [16];
   logic [7:0]  e_seg, e_t1, e_t2;

   always @(posedge clk) begin : model
      int unsigned d;
      logic [7:0]  g;
      bit          tick, wrap, acc;
      if (!rst_n) begin
         m_cyc = 0; m_ticks = 0; m_sc = 0; m_off = 0;
         m_pend = 0; m_req = 0;
         for (int i = 0; i < 16; i++) begin
            m_active[i] = 8'h00;
            m_shadow[i] = 8'h00;
         end
         e_seg = 8'h01; e_t1 = 8'h00; e_t2 = 8'h00;
      end else begin
         d = m_ticks % NUM_DIGITS;
         g = m_active[(m_off + d) % MSG_LEN];
         if (blink_mask[d] && ((m_ticks / BH) % 2 == 1)) g = 8'h00;
         e_seg = 8'(1 << d);
         e_t1  = (d < BANK_SIZE) ? g : 8'h00;
         e_t2  = (d < BANK_SIZE) ? 8'h00 : g;
         tick  = (m_cyc % DIV) == DIV - 1;
         m_cyc++;
         wrap  = tick && (d == NUM_DIGITS - 1);
         acc   = frame_valid && !m_pend;
         if (wrap) begin
            if (m_pend) begin
               m_active = m_shadow; m_pend = 0; m_off = 0; m_req = 0;
            end else if (!scroll_en) begin
               m_off = 0;
            end else if (m_req) begin
               m_off = (m_off + 1) % MSG_LEN; m_req = 0;
            end
         end
         if (acc) begin
            for (int i = 0; i < 16; i++) m_shadow[i] = frame_in[8*i +: 8];
            m_pend = 1;
         end
         if (!scroll_en) begin
            m_sc = 0; m_req = 0;
         end else if (tick) begin
            m_sc++;
            if (m_sc % SP == 0) m_req = 1;
         end
         if (tick) m_ticks++;
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      frame_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic load_counting_frame();
      for (int i = 0; i < 16; i++) frame_in[8*i +: 8] = 8'(i + 1);
   endtask

   task automatic test_reset();
      blink_mask = '0; scroll_en = 1'b0;
      do_reset();
      checks++;
      if ({seg_en, tube1, tube2, frame_ready} !== {8'h01, 8'h00, 8'h00, 1'b1}) begin
         errors++;
         $display("FAIL reset_state: got seg_en=%h tube1=%h tube2=%h ready=%b, expected 01 00 00 1",
                  seg_en, tube1, tube2, frame_ready);
      end
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         checks++;
         if ({seg_en, tube1, tube2, frame_ready} !== {e_seg, e_t1, e_t2, !m_pend}) begin
            errors++;
            $display("FAIL idle_scan@%0d: got %h %h %h %b, expected %h %h %h %b",
                     k, seg_en, tube1, tube2, frame_ready, e_seg, e_t1, e_t2, !m_pend);
         end
         checks++;
         if ({tube1, tube2, frame_ready} !== {8'h00, 8'h00, 1'b1}) begin
            errors++;
            $display("FAIL idle_blank@%0d: got tube1=%h tube2=%h ready=%b, expected 00 00 1",
                     k, tube1, tube2, frame_ready);
         end
      end
   endtask

   task automatic test_load();
      blink_mask = '0; scroll_en = 1'b0;
      do_reset();
      load_counting_frame();
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         checks++;
         if ({seg_en, tube1, tube2, frame_ready} !== {e_seg, e_t1, e_t2, !m_pend}) begin
            errors++;
            $display("FAIL load@%0d: got %h %h %h %b, expected %h %h %h %b",
                     k, seg_en, tube1, tube2, frame_ready, e_seg, e_t1, e_t2, !m_pend);
         end
         if (k == 4) begin
            checks++;
            if (frame_ready !== 1'b0) begin
               errors++;
               $display("FAIL load_ready_drop: got %b, expected 0", frame_ready);
            end
         end
         if (k < 75 && (tube1 !== 8'h00 || tube2 !== 8'h00)) begin
            errors++;
            $display("FAIL load_early_show@%0d: got tube1=%h tube2=%h, expected 00 00", k, tube1, tube2);
         end
         if (k > 90 && seg_en === 8'h04) begin
            checks++;
            if (tube1 !== 8'h03) begin
               errors++;
               $display("FAIL load_digit2: got tube1=%h, expected 03", tube1);
            end
         end
         if (k > 90 && seg_en === 8'h20) begin
            checks++;
            if (tube2 !== 8'h06) begin
               errors++;
               $display("FAIL load_digit5: got tube2=%h, expected 06", tube2);
            end
         end
         frame_valid = (k == 3);
      end
   endtask

   task automatic test_hold();
      bit sent = 0;
      bit done = 0;
      blink_mask = '0; scroll_en = 1'b0;
      do_reset();
      frame_in = {$urandom, $urandom, $urandom, $urandom};
      frame_valid = 1'b1;
      for (int k = 0; k < 260; k++) begin
         @(negedge clk);
         checks++;
         if ({seg_en, tube1, tube2, frame_ready} !== {e_seg, e_t1, e_t2, !m_pend}) begin
            errors++;
            $display("FAIL hold@%0d: got %h %h %h %b, expected %h %h %h %b",
                     k, seg_en, tube1, tube2, frame_ready, e_seg, e_t1, e_t2, !m_pend);
         end
         if (k > 0 && k < 70) begin
            checks++;
            if (frame_ready !== 1'b0) begin
               errors++;
               $display("FAIL hold_not_ready@%0d: got %b, expected 0", k, frame_ready);
            end
         end
         if (k == 0) begin
            frame_valid = 1'b0;
         end else if (k == 4) begin
            frame_in = {$urandom, $urandom, $urandom, $urandom};
            frame_valid = 1'b1;
         end else if (k > 4 && !done) begin
            if (sent) begin
               frame_valid = 1'b0;
               done = 1;
            end else if (frame_ready) begin
               sent = 1;
            end
         end
      end
      frame_valid = 1'b0;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL hold_accept_timeout: got accepted=0, expected 1");
      end
   endtask

   task automatic test_blink();
      scroll_en = 1'b0;
      blink_mask = 8'h01;
      do_reset();
      load_counting_frame();
      frame_valid = 1'b1;
      for (int k = 0; k < 500; k++) begin
         @(negedge clk);
         checks++;
         if ({seg_en, tube1, tube2, frame_ready} !== {e_seg, e_t1, e_t2, !m_pend}) begin
            errors++;
            $display("FAIL blink@%0d: got %h %h %h %b, expected %h %h %h %b",
                     k, seg_en, tube1, tube2, frame_ready, e_seg, e_t1, e_t2, !m_pend);
         end
         if (k > 90 && seg_en === 8'h02) begin
            checks++;
            if (tube1 !== 8'h02) begin
               errors++;
               $display("FAIL blink_other_digit: got tube1=%h, expected 02", tube1);
            end
         end
         frame_valid = 1'b0;
      end
   endtask

   task automatic test_scroll();
      blink_mask = '0;
      scroll_en = 1'b1;
      do_reset();
      load_counting_frame();
      frame_valid = 1'b1;
      for (int k = 0; k < 3200; k++) begin
         @(negedge clk);
         checks++;
         if ({seg_en, tube1, tube2, frame_ready} !== {e_seg, e_t1, e_t2, !m_pend}) begin
            errors++;
            $display("FAIL scroll@%0d: got %h %h %h %b, expected %h %h %h %b",
                     k, seg_en, tube1, tube2, frame_ready, e_seg, e_t1, e_t2, !m_pend);
         end
         frame_valid = 1'b0;
      end
      scroll_en = 1'b0;
      for (int k = 0; k < 250; k++) begin
         @(negedge clk);
         checks++;
         if ({seg_en, tube1, tube2, frame_ready} !== {e_seg, e_t1, e_t2, !m_pend}) begin
            errors++;
            $display("FAIL scroll_off@%0d: got %h %h %h %b, expected %h %h %h %b",
                     k, seg_en, tube1, tube2, frame_ready, e_seg, e_t1, e_t2, !m_pend);
         end
         if (k > 100 && seg_en === 8'h01) begin
            checks++;
            if (tube1 !== 8'h01) begin
               errors++;
               $display("FAIL scroll_off_home: got tube1=%h, expected 01", tube1);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      blink_mask = '0; scroll_en = 1'b0;
      do_reset();
      load_counting_frame();
      frame_valid = 1'b1;
      for (int k = 0; k < 130; k++) begin
         @(negedge clk);
         frame_valid = 1'b0;
         if (k == 100) begin
            frame_in = {$urandom, $urandom, $urandom, $urandom};
            frame_valid = 1'b1;
         end
      end
      checks++;
      if (frame_ready !== 1'b0) begin
         errors++;
         $display("FAIL midreset_pending: got ready=%b, expected 0", frame_ready);
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      checks++;
      if ({seg_en, tube1, tube2, frame_ready} !== {8'h01, 8'h00, 8'h00, 1'b1}) begin
         errors++;
         $display("FAIL midreset_state: got seg_en=%h tube1=%h tube2=%h ready=%b, expected 01 00 00 1",
                  seg_en, tube1, tube2, frame_ready);
      end
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         checks++;
         if ({seg_en, tube1, tube2, frame_ready} !== {e_seg, e_t1, e_t2, !m_pend}) begin
            errors++;
            $display("FAIL midreset@%0d: got %h %h %h %b, expected %h %h %h %b",
                     k, seg_en, tube1, tube2, frame_ready, e_seg, e_t1, e_t2, !m_pend);
         end
         checks++;
         if ({tube1, tube2} !== 16'h0000) begin
            errors++;
            $display("FAIL midreset_discard@%0d: got tube1=%h tube2=%h, expected 00 00", k, tube1, tube2);
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         checks++;
         if ({seg_en, tube1, tube2, frame_ready} !== {e_seg, e_t1, e_t2, !m_pend}) begin
            errors++;
            $display("FAIL random@%0d: got %h %h %h %b, expected %h %h %h %b",
                     k, seg_en, tube1, tube2, frame_ready, e_seg, e_t1, e_t2, !m_pend);
         end
         rst_n = ($urandom_range(0, 699) != 0);
         frame_valid = ($urandom_range(0, 29) == 0);
         if (frame_valid) frame_in = {$urandom, $urandom, $urandom, $urandom};
         if ($urandom_range(0, 149) == 0) blink_mask = 8'($urandom);
         if ($urandom_range(0, 299) == 0) scroll_en = ~scroll_en;
      end
      rst_n = 1'b1;
      frame_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_load();
      test_hold();
      test_blink();
      test_scroll();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
